aim_power_ctrl: RTL and testbench

//  Parametrised aim/power controller for the ball thrower.
//  - Turns active-low angle/power buttons into saturating Ang/Vel settings, one step per update tick.
//  - Draws the aim-arrow marker from xCount/yCount and hands Ang/Vel to the flight engine over a valid/ready launch handshake.
//  - Sits between the button inputs and the physics/VGA blocks.
//  - Locks the aim while a ball is in flight.

---
 rtl/aim_pkg.sv | 21 ++
 rtl/btn_edge.sv | 36 +++
 rtl/aim_power_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_aim_power_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aim_pkg.sv
// Shared constants for the aim/power controller: FSM encodings, request indices
// and the VGA coordinate width.
package aim_pkg;

  // FSM state encodings
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // Bit positions in the request vectors
  localparam int unsigned REQ_AUP  = 0;
  localparam int unsigned REQ_ADN  = 1;
  localparam int unsigned REQ_PUP  = 2;
  localparam int unsigned REQ_PDN  = 3;
  localparam int unsigned REQ_FIRE = 4;
  localparam int unsigned REQ_NUM  = 5;

  // VGA pixel coordinate width
  localparam int unsigned COORD_W = 10;

endpackage

// File: rtl/btn_edge.sv
// Active-low button conditioner: 2-FF synchroniser followed by a falling-edge
// (press) detector. With AIM_AUTOREPEAT_EN the synchronised held level is also
// exported so the top can auto-repeat held buttons.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
`ifdef AIM_AUTOREPEAT_EN
  output logic o_held,
`endif
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchroniser and edge history; idle level is 1 so reset gives no false press
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_fall = r_prev & ~r_sync2;
`ifdef AIM_AUTOREPEAT_EN
  assign o_held = ~r_sync2;
`endif

endmodule

// File: rtl/aim_power_ctrl.sv
// Aim/power controller for the ball thrower. Buttons become saturating Ang/Vel
// steps on each tick, the aim arrow is drawn from Ang/Vel, and fire hands the
// settings to the flight engine over a valid/ready handshake. Aim is locked
// until the flight engine reports landing.
// Optional feature: define AIM_AUTOREPEAT_EN for auto-repeat of held adjust buttons.
module aim_power_ctrl
  import aim_pkg::*;
#(
  parameter int unsigned ANG_W        = 5,
  parameter int unsigned ANG_MAX      = 16,
  parameter int unsigned VEL_W        = 3,
  parameter int unsigned VEL_MAX      = 5,
  parameter int unsigned ARROW_X0     = 31,
  parameter int unsigned ARROW_Y0     = 425,
  parameter int unsigned ARROW_SZ     = 5,
  parameter int unsigned ANG_DX       = 1,
  parameter int unsigned ANG_DY       = 4,
  parameter int unsigned VEL_DX       = 4,
  parameter int unsigned VEL_DY       = 10,
  parameter int unsigned REPEAT_TICKS = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_angleup,
  input  logic               i_angledown,
  input  logic               i_powerup,
  input  logic               i_powerdown,
  input  logic               i_fire,
  input  logic [COORD_W-1:0] i_xCount,
  input  logic [COORD_W-1:0] i_yCount,
  input  logic               i_flight_done,
  input  logic               i_launch_ready,
  output logic               o_launch_valid,
  output logic               o_busy,
  output logic               o_arrow,
  output logic [VEL_W-1:0]   o_Vel,
  output logic [ANG_W-1:0]   o_Ang
);

  logic [REQ_NUM-1:0] w_btn_n;
  logic [REQ_NUM-1:0] w_fall;
  logic [REQ_NUM-1:0] w_rep;
  logic [REQ_NUM-1:0] w_pend;
  logic [REQ_NUM-1:0] r_req;
  logic [REQ_NUM-1:0] w_req_nxt;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [ANG_W-1:0]   r_ang;
  logic [ANG_W-1:0]   w_ang_nxt;
  logic [VEL_W-1:0]   r_vel;
  logic [VEL_W-1:0]   w_vel_nxt;
  logic               r_arrow;
  logic [COORD_W-1:0] w_ax;
  logic [COORD_W-1:0] w_ay;
  logic               w_in_x;
  logic               w_in_y;

  assign w_btn_n[REQ_AUP]  = i_angleup;
  assign w_btn_n[REQ_ADN]  = i_angledown;
  assign w_btn_n[REQ_PUP]  = i_powerup;
  assign w_btn_n[REQ_PDN]  = i_powerdown;
  assign w_btn_n[REQ_FIRE] = i_fire;

`ifdef AIM_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);

  logic [REQ_NUM-1:0] w_held;
  logic [3:0]         w_held_adj;
  logic [3:0]         r_rep_btn;
  logic [3:0]         w_rep_btn_nxt;
  logic [RepW-1:0]    r_rep_cnt;
  logic [RepW-1:0]    w_rep_cnt_nxt;
`endif

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_btn
    btn_edge u_btn_edge (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn_n (w_btn_n[g]),
`ifdef AIM_AUTOREPEAT_EN
      .o_held  (w_held[g]),
`endif
      .o_fall  (w_fall[g])
    );
  end

`ifdef AIM_AUTOREPEAT_EN
  // Fire is excluded: only the four adjust buttons repeat
  assign w_held_adj = w_held[3:0];

  // Repeat timer: restarts when the held set changes, re-issues every REPEAT_TICKS ticks
  always_comb begin
    w_rep         = '0;
    w_rep_btn_nxt = r_rep_btn;
    w_rep_cnt_nxt = r_rep_cnt;
    if (i_tick) begin
      if (w_held_adj != r_rep_btn) begin
        w_rep_btn_nxt = w_held_adj;
        w_rep_cnt_nxt = '0;
      end else if (w_held_adj != 4'b0) begin
        if (r_rep_cnt == RepW'(REPEAT_TICKS - 1)) begin
          w_rep_cnt_nxt = '0;
          w_rep[3:0]    = w_held_adj;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + 1'b1;
        end
      end
    end
  end

  // Repeat timer state
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rep_btn <= '0;
      r_rep_cnt <= '0;
    end else begin
      r_rep_btn <= w_rep_btn_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
    end
  end
`else
  assign w_rep = '0;
`endif

  // Edges arriving on the tick clock itself are folded into this tick's decision
  assign w_pend = r_req | w_fall | w_rep;

  // Request consumption, saturating Ang/Vel update and launch FSM
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_ang_nxt   = r_ang;
    w_vel_nxt   = r_vel;
    case (r_state)
      S_IDLE: begin
        if (i_tick) begin
          w_req_nxt = '0;
          if (w_pend[REQ_FIRE]) begin
            w_state_nxt = S_LAUNCH;
          end else if (w_pend[REQ_AUP]) begin
            if (r_ang < ANG_W'(ANG_MAX)) w_ang_nxt = r_ang + 1'b1;
          end else if (w_pend[REQ_ADN]) begin
            if (r_ang != '0) w_ang_nxt = r_ang - 1'b1;
          end else if (w_pend[REQ_PUP]) begin
            if (r_vel < VEL_W'(VEL_MAX)) w_vel_nxt = r_vel + 1'b1;
          end else if (w_pend[REQ_PDN]) begin
            if (r_vel != '0) w_vel_nxt = r_vel - 1'b1;
          end
        end else begin
          w_req_nxt = w_pend;
        end
      end
      S_LAUNCH: begin
        w_req_nxt = '0;
        if (i_launch_ready) w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        w_req_nxt = '0;
        if (i_flight_done) w_state_nxt = S_IDLE;
      end
      default: begin
        w_req_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control and setting registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_ang   <= '0;
      r_vel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_ang   <= w_ang_nxt;
      r_vel   <= w_vel_nxt;
    end
  end

  // Arrow origin from the current settings. Only the low 10 bits of the signed
  // 11-bit result are kept, which 10-bit modular arithmetic gives directly.
  assign w_ax = COORD_W'(ARROW_X0) - COORD_W'(r_ang) * COORD_W'(ANG_DX)
              + COORD_W'(r_vel) * COORD_W'(VEL_DX);
  assign w_ay = COORD_W'(ARROW_Y0) - COORD_W'(r_ang) * COORD_W'(ANG_DY)
              - COORD_W'(r_vel) * COORD_W'(VEL_DY);

  // Extra bit keeps ax+ARROW_SZ from wrapping near the right screen edge
  assign w_in_x = ({1'b0, i_xCount} > {1'b0, w_ax}) &&
                  ({1'b0, i_xCount} < ({1'b0, w_ax} + (COORD_W + 1)'(ARROW_SZ)));
  assign w_in_y = ({1'b0, i_yCount} > {1'b0, w_ay}) &&
                  ({1'b0, i_yCount} < ({1'b0, w_ay} + (COORD_W + 1)'(ARROW_SZ)));

  // Arrow pixel flag, one clock behind the scan coordinates
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_arrow <= 1'b0;
    end else begin
      r_arrow <= w_in_x && w_in_y;
    end
  end

  assign o_launch_valid = (r_state == S_LAUNCH);
  assign o_busy         = (r_state == S_LAUNCH) || (r_state == S_LOCKED);
  assign o_arrow        = r_arrow;
  assign o_Ang          = r_ang;
  assign o_Vel          = r_vel;

endmodule

// File: tb/tb_aim_power_ctrl.sv
// Directed self-checking bench for aim_power_ctrl (default parameters).
`timescale 1ns/1ps
module tb_aim_power_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [4:0] btn_n = 5'b11111;  // {fire, pdn, pup, adn, aup}
  logic [9:0] xcount = 10'd0;
  logic [9:0] ycount = 10'd0;
  logic       flight_done = 1'b0;
  logic       launch_ready = 1'b0;
  logic       launch_valid;
  logic       busy;
  logic       arrow;
  logic [2:0] vel;
  logic [4:0] ang;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] B_AUP  = 5'b00001;
  localparam logic [4:0] B_ADN  = 5'b00010;
  localparam logic [4:0] B_PUP  = 5'b00100;
  localparam logic [4:0] B_PDN  = 5'b01000;
  localparam logic [4:0] B_FIRE = 5'b10000;

  aim_power_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tick         (tick),
    .i_angleup      (btn_n[0]),
    .i_angledown    (btn_n[1]),
    .i_powerup      (btn_n[2]),
    .i_powerdown    (btn_n[3]),
    .i_fire         (btn_n[4]),
    .i_xCount       (xcount),
    .i_yCount       (ycount),
    .i_flight_done  (flight_done),
    .i_launch_ready (launch_ready),
    .o_launch_valid (launch_valid),
    .o_busy         (busy),
    .o_arrow        (arrow),
    .o_Vel          (vel),
    .o_Ang          (ang)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [4:0] mask);
    @(negedge clk) btn_n = ~mask;
    repeat (4) @(negedge clk);
    btn_n = 5'b11111;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk) begin xcount = x; ycount = y; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ang !== 5'd0 || vel !== 3'd0 || launch_valid !== 1'b0 || busy !== 1'b0
        || arrow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ang=%0d vel=%0d lv=%b busy=%b arrow=%b, required 0 0 0 0 0",
               ang, vel, launch_valid, busy, arrow);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    probe(10'd33, 10'd427);
    n_tests++;
    if (arrow !== 1'b1) begin
      n_fail++;
      $display("FAIL arrow_inside_origin: got %b required 1", arrow);
    end
    probe(10'd36, 10'd427);
    n_tests++;
    if (arrow !== 1'b0) begin
      n_fail++;
      $display("FAIL arrow_right_border: got %b required 0", arrow);
    end
  endtask

  task automatic test_angle_saturate();
    for (int i = 0; i < 20; i++) begin
      press(B_AUP);
      do_tick();
      if (i == 3) begin
        n_tests++;
        if (ang !== 5'd4) begin
          n_fail++;
          $display("FAIL ang_after_4: got %0d required 4", ang);
        end
      end
    end
    n_tests++;
    if (ang !== 5'd16) begin
      n_fail++;
      $display("FAIL ang_saturate_max: got %0d required 16", ang);
    end
    press(B_ADN);
    do_tick();
    n_tests++;
    if (ang !== 5'd15) begin
      n_fail++;
      $display("FAIL ang_down_from_max: got %0d required 15", ang);
    end
    // ax = 31-15 = 16, ay = 425-60 = 365
    probe(10'd17, 10'd366);
    n_tests++;
    if (arrow !== 1'b1) begin
      n_fail++;
      $display("FAIL arrow_moved_inside: got %b required 1", arrow);
    end
    probe(10'd16, 10'd366);
    n_tests++;
    if (arrow !== 1'b0) begin
      n_fail++;
      $display("FAIL arrow_moved_left_border: got %b required 0", arrow);
    end
    probe(10'd33, 10'd427);
    n_tests++;
    if (arrow !== 1'b0) begin
      n_fail++;
      $display("FAIL arrow_old_origin: got %b required 0", arrow);
    end
  endtask

  task automatic test_priority();
    press(B_AUP | B_PUP);
    do_tick();
    n_tests++;
    if (ang !== 5'd16 || vel !== 3'd0) begin
      n_fail++;
      $display("FAIL prio_aup_over_pup: ang=%0d vel=%0d required 16 0", ang, vel);
    end
    do_tick();
    n_tests++;
    if (vel !== 3'd0) begin
      n_fail++;
      $display("FAIL pup_dropped: vel=%0d required 0", vel);
    end
    press(B_PDN);
    do_tick();
    n_tests++;
    if (vel !== 3'd0) begin
      n_fail++;
      $display("FAIL vel_floor: vel=%0d required 0", vel);
    end
    press(B_PUP);
    do_tick();
    n_tests++;
    if (vel !== 3'd1) begin
      n_fail++;
      $display("FAIL vel_up: vel=%0d required 1", vel);
    end
    // ax = 31-16+4 = 19, ay = 425-64-10 = 351
    probe(10'd20, 10'd352);
    n_tests++;
    if (arrow !== 1'b1) begin
      n_fail++;
      $display("FAIL arrow_with_vel: got %b required 1", arrow);
    end
  endtask

  task automatic test_launch_lock();
    press(B_FIRE | B_ADN);
    do_tick();
    n_tests++;
    if (launch_valid !== 1'b1 || busy !== 1'b1 || ang !== 5'd16) begin
      n_fail++;
      $display("FAIL fire_to_launch: lv=%b busy=%b ang=%0d required 1 1 16",
               launch_valid, busy, ang);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (launch_valid !== 1'b1 || ang !== 5'd16 || vel !== 3'd1) begin
        n_fail++;
        $display("FAIL launch_hold_%0d: lv=%b ang=%0d vel=%0d required 1 16 1",
                 i, launch_valid, ang, vel);
      end
    end
    launch_ready = 1'b1;
    @(negedge clk) launch_ready = 1'b0;
    n_tests++;
    if (launch_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_to_locked: lv=%b busy=%b required 0 1", launch_valid, busy);
    end
    press(B_ADN);
    do_tick();
    n_tests++;
    if (ang !== 5'd16 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL locked_ignores_press: ang=%0d busy=%b required 16 1", ang, busy);
    end
    flight_done = 1'b1;
    @(negedge clk) flight_done = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flight_done_unlock: busy=%b required 0", busy);
    end
    do_tick();
    n_tests++;
    if (ang !== 5'd16) begin
      n_fail++;
      $display("FAIL locked_press_cleared: ang=%0d required 16", ang);
    end
    press(B_ADN);
    do_tick();
    n_tests++;
    if (ang !== 5'd15) begin
      n_fail++;
      $display("FAIL press_after_unlock: ang=%0d required 15", ang);
    end
  endtask

  task automatic test_async_reset();
    press(B_FIRE);
    do_tick();
    launch_ready = 1'b1;
    @(negedge clk) launch_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || ang !== 5'd15 || vel !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_reset_locked: busy=%b ang=%0d vel=%0d required 1 15 1", busy, ang, vel);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (ang !== 5'd0 || vel !== 3'd0 || launch_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: ang=%0d vel=%0d lv=%b busy=%b required 0 0 0 0",
               ang, vel, launch_valid, busy);
    end
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_powerup();
    logic [2:0] exp_vel;
`ifdef AIM_AUTOREPEAT_EN
    exp_vel = 3'd5;
`else
    exp_vel = 3'd1;
`endif
    @(negedge clk) btn_n = ~B_PUP;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      do_tick();
      repeat (2) @(negedge clk);
    end
    btn_n = 5'b11111;
    repeat (3) @(negedge clk);
    n_tests++;
    if (vel !== exp_vel) begin
      n_fail++;
      $display("FAIL hold_powerup: vel=%0d required %0d", vel, exp_vel);
    end
  endtask

  initial begin
    test_reset();
    test_angle_saturate();
    test_priority();
    test_launch_lock();
    test_async_reset();
    test_hold_powerup();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
